// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and helpers for the key debouncer
package key_pkg;

    localparam int DEB_CYCLES_SIM         = 20;
    localparam int DEB_CYCLES_BOARD_50MHZ = 1_000_000;

    // Pin level seen when no key is pressed.
    function automatic logic key_idle_lvl(input bit active_low);
        return active_low;
    endfunction

    // Ceiling log2 with a minimum of 1 so single-entry ranges still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key: two-flop sync, stability counter, press/release pulses
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int DEB_CYCLES     = DEB_CYCLES_SIM,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic press_next
);

    localparam int               CNT_W   = clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic             IDLE    = key_idle_lvl(KEY_ACTIVE_LOW);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             accept;
    logic             release_next;

    always_comb begin
        lvl          = sync2 ^ KEY_ACTIVE_LOW;
        accept       = (lvl != key_state) && (cnt == CNT_MAX);
        press_next   = accept & lvl;
        release_next = accept & ~lvl;
    end

    // Sync stages reset to the idle level so a key held through reset is seen as a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= IDLE;
            sync2       <= IDLE;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            key_press   <= press_next;
            key_release <= release_next;
            if (lvl == key_state) begin
                cnt <= '0;
            end else if (accept) begin
                key_state <= lvl;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - NUM_KEYS debounced keys with registered press-event encoder
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int DEB_CYCLES     = DEB_CYCLES_SIM,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_KEYS-1:0]          key_in,
    output logic [NUM_KEYS-1:0]          key_state,
    output logic [NUM_KEYS-1:0]          key_press,
    output logic [NUM_KEYS-1:0]          key_release,
    output logic                         key_valid,
    output logic [clog2(NUM_KEYS)-1:0]   key_code
);

    localparam int CODE_W = clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0] press_next;
    logic [CODE_W-1:0]   code_next;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_keys
        key_debounce_cell #(
            .DEB_CYCLES     (DEB_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .key_in      (key_in[k]),
            .key_state   (key_state[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k]),
            .press_next  (press_next[k])
        );
    end

    // Scan downward so the lowest pressed index wins.
    always_comb begin
        code_next = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press_next[i]) code_next = CODE_W'(i);
        end
    end

    // Encoder uses the cells' next-pulse terms so it lands on the same edge as key_press.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= |press_next;
            if (|press_next) key_code <= code_next;
        end
    end

endmodule
